// File: rtl/axi_add_arbiter.sv
// axi_add_arbiter: round-robin front end sharing one pipelined AXI-stream adder.
// Requester ID rides in the adder user field; results are routed back by ID.
module axi_add_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DWIDTH          = 64,
  parameter int IDW             = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic [NUM_REQ-1:0]        s_valid,
  output logic [NUM_REQ-1:0]        s_ready,
  input  logic [NUM_REQ*DWIDTH-1:0] s_data_a,
  input  logic [NUM_REQ*DWIDTH-1:0] s_data_b,
  output logic [NUM_REQ-1:0]        r_valid,
  input  logic [NUM_REQ-1:0]        r_ready,
  output logic [DWIDTH-1:0]         r_result,
  output logic                      r_carry,
  output logic                      add_s_valid,
  input  logic                      add_s_ready,
  output logic [DWIDTH-1:0]         add_s_data_a,
  output logic [DWIDTH-1:0]         add_s_data_b,
  output logic [IDW-1:0]            add_s_user,
  input  logic                      add_m_valid,
  output logic                      add_m_ready,
  input  logic [DWIDTH-1:0]         add_m_result,
  input  logic                      add_m_carry,
  input  logic [IDW-1:0]            add_m_user,
  output logic [7:0]                outstanding,
  output logic                      err
);

  localparam logic [7:0]   MAX_C = 8'(MAX_OUTSTANDING);
  localparam logic [IDW:0] NR_C  = (IDW+1)'(NUM_REQ);

  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [7:0]             out_q, out_d;
  logic                   err_q, err_d;

  logic [2*NUM_REQ-1:0]   dbl;
  logic [NUM_REQ-1:0]     rot;
  logic [IDW:0]           sum;
  logic [IDW:0]           nxt;
  logic [IDW-1:0]         gnt;
  logic                   any_v;
  logic                   credit_ok;
  logic                   issue;
  logic                   ret;
  logic                   user_ok;
  logic                   sel_rdy;

  assign dbl       = {s_valid, s_valid};
  assign rot       = NUM_REQ'(dbl >> rr_ptr_q);
  assign credit_ok = (out_q < MAX_C);

  // Rotated priority scan: lowest offset from the pointer wins.
  always_comb begin
    any_v = 1'b0;
    sum   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        any_v = 1'b1;
        sum   = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      end
    end
    if (sum >= NR_C) sum = sum - NR_C;
    gnt = sum[IDW-1:0];
  end

  // Forward the granted operands and raise its ready.
  always_comb begin
    add_s_data_a = '0;
    add_s_data_b = '0;
    s_ready      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == IDW'(i)) begin
        add_s_data_a = s_data_a[i*DWIDTH +: DWIDTH];
        add_s_data_b = s_data_b[i*DWIDTH +: DWIDTH];
        s_ready[i]   = aresetn & any_v & credit_ok & add_s_ready;
      end
    end
  end

  assign add_s_valid = aresetn & any_v & credit_ok;
  assign add_s_user  = gnt;
  assign issue       = add_s_valid & add_s_ready;

  // Route the adder output to the requester named in the user field.
  always_comb begin
    r_valid = '0;
    user_ok = 1'b0;
    sel_rdy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (add_m_user == IDW'(i)) begin
        user_ok    = 1'b1;
        sel_rdy    = r_ready[i];
        r_valid[i] = aresetn & add_m_valid;
      end
    end
  end

  assign add_m_ready = aresetn & (user_ok ? sel_rdy : 1'b1);
  assign r_result    = add_m_result;
  assign r_carry     = add_m_carry;
  assign ret         = add_m_valid & add_m_ready;

  // Next pointer, credit count and sticky error.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    out_d    = out_q;
    err_d    = err_q;
    nxt      = {1'b0, gnt} + 1'b1;
    if (nxt == NR_C) nxt = '0;
    if (issue) rr_ptr_d = nxt[IDW-1:0];
    if (issue && !ret) begin
      out_d = out_q + 8'd1;
    end else if (ret && !issue && out_q != 8'd0) begin
      out_d = out_q - 8'd1;
    end
    if (ret && out_q == 8'd0) err_d = 1'b1;
    if (add_m_valid && !user_ok) err_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr_q <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  assign outstanding = out_q;
  assign err         = err_q;

endmodule

// File: tb/tb_axi_add_arbiter.sv
// tb_axi_add_arbiter: random/directed bench with a behavioural adder agent,
// a per-requester result scoreboard and a credit/round-robin reference model.
module tb_axi_add_arbiter;

  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int IW   = 2;
  localparam int MAXO = 8;

  logic            clk;
  logic            aresetn;
  logic [N-1:0]    s_valid, s_ready;
  logic [N*DW-1:0] s_data_a, s_data_b;
  logic [N-1:0]    r_valid, r_ready;
  logic [DW-1:0]   r_result;
  logic            r_carry;
  logic            add_s_valid, add_s_ready;
  logic [DW-1:0]   add_s_data_a, add_s_data_b;
  logic [IW-1:0]   add_s_user;
  logic            add_m_valid, add_m_ready;
  logic [DW-1:0]   add_m_result;
  logic            add_m_carry;
  logic [IW-1:0]   add_m_user;
  logic [7:0]      outstanding;
  logic            err;

  axi_add_arbiter #(
    .NUM_REQ(N), .DWIDTH(DW), .IDW(IW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data_a(s_data_a), .s_data_b(s_data_b),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_result(r_result), .r_carry(r_carry),
    .add_s_valid(add_s_valid), .add_s_ready(add_s_ready),
    .add_s_data_a(add_s_data_a), .add_s_data_b(add_s_data_b),
    .add_s_user(add_s_user),
    .add_m_valid(add_m_valid), .add_m_ready(add_m_ready),
    .add_m_result(add_m_result), .add_m_carry(add_m_carry),
    .add_m_user(add_m_user),
    .outstanding(outstanding), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [64:0] v;
    logic [1:0]  u;
    int          rdy;
  } ent_t;

  int          n_cmp, n_bad;
  logic [63:0] ra[N], rb[N];
  logic [N-1:0] rv;
  logic [64:0] sb[N][$];
  ent_t        aq[$];
  int          cyc, exp_out, ptr;
  bit          exp_err;
  int          iss_cnt[N];
  int          rdy_mode, ar_mode, p_new;
  logic [N-1:0] req_en;
  bit          inject, injected;

  task automatic chk(input string tag, input logic [64:0] obs,
                     input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_op(input int i);
    ra[i] = {$urandom, $urandom};
    rb[i] = {$urandom, $urandom};
    if ($urandom_range(3) == 0) ra[i] = '1;
    rv[i] = 1'b1;
  endtask

  task automatic drive();
    s_valid = rv;
    for (int i = 0; i < N; i++) begin
      s_data_a[i*DW +: DW] = ra[i];
      s_data_b[i*DW +: DW] = rb[i];
      case (rdy_mode)
        0: r_ready[i] = ($urandom_range(3) != 0);
        1: r_ready[i] = 1'b1;
        default: r_ready[i] = 1'b0;
      endcase
    end
    add_s_ready = (ar_mode == 1) ? 1'b1 : ($urandom_range(4) != 0);
    injected = 1'b0;
    if (inject) begin
      add_m_valid  = 1'b1;
      add_m_user   = 2'd1;
      add_m_result = 64'hDEAD_BEEF;
      add_m_carry  = 1'b0;
      injected     = 1'b1;
      inject       = 1'b0;
    end else if (aq.size() > 0 && aq[0].rdy <= cyc) begin
      add_m_valid  = 1'b1;
      add_m_user   = aq[0].u;
      add_m_result = aq[0].v[63:0];
      add_m_carry  = aq[0].v[64];
    end else begin
      add_m_valid  = 1'b0;
      add_m_user   = 2'($urandom);
      add_m_result = {$urandom, $urandom};
      add_m_carry  = 1'($urandom);
    end
  endtask

  task automatic tick();
    int g;
    bit ev, iss, ret, emr, push, pop;
    logic [N-1:0] esr, erv;
    logic [63:0] pa, pb;
    logic [1:0] pu, mu;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (g < 0 && rv[idx]) g = idx;
    end
    ev  = (g >= 0) && (exp_out < MAXO);
    esr = '0;
    if (ev && add_s_ready) esr[g] = 1'b1;
    chk("outstanding", outstanding, exp_out);
    chk("err", err, exp_err);
    chk("add_s_valid", add_s_valid, ev);
    chk("s_ready", s_ready, esr);
    if (ev) begin
      chk("add_s_user", add_s_user, g);
      chk("add_s_data_a", add_s_data_a, ra[g]);
      chk("add_s_data_b", add_s_data_b, rb[g]);
    end
    mu  = add_m_user;
    erv = add_m_valid ? (N'(1) << mu) : '0;
    emr = r_ready[mu];
    chk("r_valid", r_valid, erv);
    chk("add_m_ready", add_m_ready, emr);
    iss = ev && add_s_ready;
    ret = add_m_valid && emr;
    if (ret && !injected) begin
      chk("sb_nonempty", sb[mu].size() != 0, 1);
      if (sb[mu].size() != 0) begin
        chk("result", {r_carry, r_result}, sb[mu].pop_front());
      end
    end
    push = add_s_valid && add_s_ready;
    pop  = add_m_valid && add_m_ready;
    pa = add_s_data_a;
    pb = add_s_data_b;
    pu = add_s_user;
    @(posedge clk);
    #1;
    cyc++;
    if (ret && exp_out == 0) exp_err = 1'b1;
    if (iss && !ret) exp_out++;
    else if (ret && !iss && exp_out > 0) exp_out--;
    if (iss) begin
      sb[g].push_back({1'b0, ra[g]} + {1'b0, rb[g]});
      iss_cnt[g]++;
      ptr = (g + 1) % N;
      rv[g] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (!rv[i] && req_en[i] && $urandom_range(99) < p_new) new_op(i);
    end
    if (pop && !injected) void'(aq.pop_front());
    if (push) begin
      ent_t e;
      e.v   = {1'b0, pa} + {1'b0, pb};
      e.u   = pu;
      e.rdy = cyc + $urandom_range(0, 2);
      aq.push_back(e);
    end
    drive();
  endtask

  task automatic drain();
    int t;
    req_en   = '0;
    p_new    = 0;
    rdy_mode = 1;
    t = 0;
    while ((exp_out != 0 || rv != '0) && t < 300) begin
      tick();
      t++;
    end
    chk("drain_bound", t < 300, 1);
  endtask

  task automatic fill_all();
    for (int i = 0; i < N; i++) if (!rv[i]) new_op(i);
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tot;
    n_cmp = 0; n_bad = 0; cyc = 0; exp_out = 0; ptr = 0; exp_err = 0;
    rv = '0; req_en = '0; p_new = 0; rdy_mode = 1; ar_mode = 1;
    inject = 0; injected = 0;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0; rb[i] = '0; iss_cnt[i] = 0;
    end
    aresetn = 1'b0;
    drive();
    s_valid = '1;
    add_m_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_add_s_valid", add_s_valid, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_add_m_ready", add_m_ready, 0);
    drive();
    aresetn = 1'b1;

    // Single op from requester 1: all-ones + 1 wraps with carry.
    ra[1] = '1; rb[1] = 64'd1; rv[1] = 1'b1;
    drive();
    tick();
    chk("single_out1", outstanding, 1);
    t = 0;
    while ((sb[1].size() != 0 || exp_out != 0) && t < 50) begin
      tick();
      t++;
    end
    chk("single_bound", t < 50, 1);
    chk("single_out0", outstanding, 0);

    // Round-robin fairness with all requesters continuously valid.
    req_en = '1; p_new = 100; rdy_mode = 1; ar_mode = 1;
    fill_all();
    for (int i = 0; i < N; i++) iss_cnt[i] = 0;
    repeat (40) tick();
    tot = 0;
    for (int i = 0; i < N; i++) begin
      chk("rr_share", iss_cnt[i], 10);
      tot += iss_cnt[i];
    end
    chk("rr_total", tot, 40);
    drain();

    // Credit limit with results blocked.
    req_en = '1; p_new = 100; rdy_mode = 2; ar_mode = 1;
    fill_all();
    for (int i = 0; i < N; i++) iss_cnt[i] = 0;
    repeat (14) tick();
    tot = 0;
    for (int i = 0; i < N; i++) tot += iss_cnt[i];
    chk("credit_issues", tot, MAXO);
    chk("credit_full", outstanding, MAXO);
    chk("credit_stall", add_s_valid, 0);
    drain();

    // Random traffic with random back-pressure on both sides.
    req_en = '1; p_new = 50; rdy_mode = 0; ar_mode = 0;
    repeat (300) tick();
    drain();
    ar_mode = 1;

    // Spurious return with no credit outstanding sets sticky err.
    inject = 1'b1;
    drive();
    tick();
    repeat (3) tick();
    chk("err_sticky", err, 1);

    // Asynchronous reset with operations in flight.
    req_en = '1; p_new = 100; rdy_mode = 2;
    fill_all();
    repeat (5) tick();
    chk("pre_rst_out", outstanding, 5);
    aresetn = 1'b0;
    #1;
    chk("arst_outstanding", outstanding, 0);
    chk("arst_err", err, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_add_s_valid", add_s_valid, 0);
    chk("arst_r_valid", r_valid, 0);
    chk("arst_add_m_ready", add_m_ready, 0);
    @(posedge clk);
    #1;
    aq.delete();
    for (int i = 0; i < N; i++) sb[i].delete();
    exp_out = 0; exp_err = 0; ptr = 0;
    rdy_mode = 1; req_en = '0; p_new = 0;
    drive();
    aresetn = 1'b1;
    tick();
    chk("post_rst_issue", iss_cnt[0] > 0, 1);
    drain();
    chk("final_out", outstanding, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
